// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue
//
// Fetch stage that decouples the PC sequencer from instruction memory latency.
// Word fetches are issued over a req/gnt/rvalid handshake, returned words are
// buffered with their PCs in a DEPTH-entry in-order queue, and the head entry
// is presented to decode. Branch redirects flush the queue and squash every
// response still in flight.
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to suppress fetches at or
// beyond IMEM_WORDS*4 and raise the sticky fetchFault flag. Without the macro
// fetchFault is tied 0 and addresses wrap freely.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   haltSignal     in   stop issuing new fetches
//   hazardDetected in   decode stall, head entry is held
//   branchTaken    in   one-cycle redirect pulse
//   branchAddress  in   redirect target (bits [1:0] ignored)
//   imemReq        out  fetch request valid
//   imemAddr       out  word-aligned fetch address
//   imemGnt        in   memory accepts the request this cycle
//   imemRvalid     in   in-order response valid
//   imemRdata      in   response instruction word
//   instrValid     out  head entry valid
//   instruction    out  head instruction, 0 when empty
//   pc             out  head PC, 0 when empty
//   pcPlus4        out  pc + 4 (wrapping)
//   fetchFault     out  sticky out-of-bounds flag
module instruction_prefetch_queue #(
  parameter int unsigned              ADDRESSWIDTH = 32,
  parameter int unsigned              DATAWIDTH    = 32,
  parameter int unsigned              DEPTH        = 4,
  parameter logic [ADDRESSWIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned              IMEM_WORDS   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    haltSignal,
  input  logic                    hazardDetected,
  input  logic                    branchTaken,
  input  logic [ADDRESSWIDTH-1:0] branchAddress,
  output logic                    imemReq,
  output logic [ADDRESSWIDTH-1:0] imemAddr,
  input  logic                    imemGnt,
  input  logic                    imemRvalid,
  input  logic [DATAWIDTH-1:0]    imemRdata,
  output logic                    instrValid,
  output logic [DATAWIDTH-1:0]    instruction,
  output logic [ADDRESSWIDTH-1:0] pc,
  output logic [ADDRESSWIDTH-1:0] pcPlus4,
  output logic                    fetchFault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDRESSWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  ptr_t                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  ptr_t                    tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  cnt_t                    count_q, count_d;
  cnt_t                    out_q, out_d;
  cnt_t                    drop_q, drop_d;

  logic [DATAWIDTH-1:0]    data_q [DEPTH];
  logic [ADDRESSWIDTH-1:0] qpc_q  [DEPTH];
  // PC of each in-flight request, consumed in the same order responses return.
  logic [ADDRESSWIDTH-1:0] tag_q  [DEPTH];

  logic [ADDRESSWIDTH-1:0] branch_tgt;
  logic [CW:0]             occupancy;
  logic                    space, want_issue, issue, accept, keep, pop, push;
  logic                    fault_q, in_range;

  assign branch_tgt = branchAddress & ~ADDRESSWIDTH'(3);
  // Buffered plus in-flight entries must never exceed the queue size, so every
  // response is guaranteed a slot.
  assign occupancy  = {1'b0, count_q} + {1'b0, out_q};
  assign space      = occupancy < (CW+1)'(DEPTH);
  assign want_issue = reset && !haltSignal && !branchTaken && !fault_q && space;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDRESSWIDTH+2:0] IMEM_BYTES = ((ADDRESSWIDTH+3)'(IMEM_WORDS)) << 2;
  logic tgt_in_range;

  assign in_range     = {3'b000, fetch_pc_q} < IMEM_BYTES;
  assign tgt_in_range = {3'b000, branch_tgt} < IMEM_BYTES;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (branchTaken) begin
      fault_q <= fault_q && !tgt_in_range;
    end else if (want_issue && !in_range) begin
      fault_q <= 1'b1;
    end
  end
`else
  // IMEM_WORDS only has meaning with the bounds check; the term is always 0.
  assign fault_q  = 1'b0 & (IMEM_WORDS == 0);
  assign in_range = 1'b1;
`endif

  assign imemReq    = want_issue && in_range;
  assign imemAddr   = fetch_pc_q;
  assign fetchFault = fault_q;

  assign issue  = imemReq && imemGnt;
  // A response with nothing outstanding cannot belong to us and is ignored.
  assign accept = imemRvalid && (out_q != '0);
  assign keep   = accept && !branchTaken && (drop_q == '0);
  assign pop    = instrValid && !hazardDetected && !branchTaken;
  assign push   = keep && ((count_q != CW'(DEPTH)) || pop);

  // Head mux: no bypass, a response reaches decode one cycle after it returns.
  assign instrValid  = (count_q != '0);
  assign instruction = instrValid ? data_q[rd_ptr_q] : '0;
  assign pc          = instrValid ? qpc_q[rd_ptr_q] : '0;
  assign pcPlus4     = pc + ADDRESSWIDTH'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(issue) - CW'(accept);

    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDRESSWIDTH'(4);
      tag_wr_d   = tag_wr_q + ptr_t'(1);
    end
    if (accept) begin
      tag_rd_d = tag_rd_q + ptr_t'(1);
    end

    if (branchTaken) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = branch_tgt;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      drop_d     = out_q - CW'(accept);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (accept && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is only ever read under a valid count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_q[tag_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      data_q[wr_ptr_q] <= imemRdata;
      qpc_q[wr_ptr_q]  <= tag_q[tag_rd_q];
    end
  end

endmodule
